// File: rtl/seg_frame_decoder.sv
// Recovers hex digits from eight active-low 7-segment buses once they have been stable, one digit per cycle.
// Optional macro SEG_DECODE_CHANGE_ONLY_EN suppresses frames identical to the last accepted one.
module seg_frame_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg0,
  input  logic [6:0]  seg1,
  input  logic [6:0]  seg2,
  input  logic [6:0]  seg3,
  input  logic [6:0]  seg4,
  input  logic [6:0]  seg5,
  input  logic [6:0]  seg6,
  input  logic [6:0]  seg7,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] digits,
  output logic [7:0]  blank_mask,
  output logic [7:0]  err_mask,
  output logic [15:0] frame_cnt
);

  localparam int SCW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Returns {err, blank, nibble} for one active-low abcdefg pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b000000;
    case (s)
      7'b0000001: r = 6'h00;
      7'b1001111: r = 6'h01;
      7'b0010010: r = 6'h02;
      7'b0000110: r = 6'h03;
      7'b1001100: r = 6'h04;
      7'b0100100: r = 6'h05;
      7'b0100000: r = 6'h06;
      7'b0001111: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0000100: r = 6'h09;
      7'b0001000: r = 6'h0A;
      7'b1100000: r = 6'h0B;
      7'b0110001: r = 6'h0C;
      7'b1000010: r = 6'h0D;
      7'b0110000: r = 6'h0E;
      7'b0111000: r = 6'h0F;
      7'b1111111: r = 6'b010000;
      default:    r = 6'b100000;
    endcase
    return r;
  endfunction

  state_t          state, state_nx;
  logic [7:0][6:0] bus, in_q, snap;
  logic [SCW-1:0]  stab_cnt;
  logic [2:0]      idx;
  logic [7:0][3:0] dig_sh, dig_nx, dig_q;
  logic [7:0]      blank_sh, blank_nx, err_sh, err_nx;
  logic [5:0]      dec;
  logic            hs, scan_last, capture, suppress, emit;

  assign bus       = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
  assign hs        = (state == OUT) && ready;
  assign scan_last = (state == SCAN) && (idx == 3'd7);
  assign capture   = (state == IDLE) && (stab_cnt == STAB_MAX);
  assign emit      = scan_last && !suppress;
  assign digits    = dig_q;

  // Shadow update for the digit under decode; on the last digit this is the complete frame.
  always_comb begin
    dec           = decode_seg(snap[idx]);
    dig_nx        = dig_sh;
    blank_nx      = blank_sh;
    err_nx        = err_sh;
    dig_nx[idx]   = dec[3:0];
    blank_nx[idx] = dec[4];
    err_nx[idx]   = dec[5];
  end

`ifdef SEG_DECODE_CHANGE_ONLY_EN
  logic [7:0][3:0] last_dig;
  logic [7:0]      last_blank, last_err;

  assign suppress = scan_last &&
                    ({dig_nx, blank_nx, err_nx} == {last_dig, last_blank, last_err});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dig   <= '0;
      last_blank <= '0;
      last_err   <= '0;
    end else if (hs) begin
      last_dig   <= dig_q;
      last_blank <= blank_mask;
      last_err   <= err_mask;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture) state_nx = SCAN;
      SCAN:    if (scan_last) state_nx = suppress ? IDLE : OUT;
      OUT:     if (ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stability window restarts on any bus change and after every accepted or dropped frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q     <= '0;
      stab_cnt <= '0;
    end else begin
      in_q <= bus;
      if (hs || suppress)
        stab_cnt <= '0;
      else if (bus != in_q)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap       <= '0;
      idx        <= '0;
      dig_sh     <= '0;
      blank_sh   <= '0;
      err_sh     <= '0;
      dig_q      <= '0;
      blank_mask <= '0;
      err_mask   <= '0;
      valid      <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (capture) begin
        snap <= in_q;
        idx  <= 3'd0;
      end
      if (state == SCAN) begin
        idx      <= idx + 3'd1;
        dig_sh   <= dig_nx;
        blank_sh <= blank_nx;
        err_sh   <= err_nx;
      end
      if (emit) begin
        dig_q      <= dig_nx;
        blank_mask <= blank_nx;
        err_mask   <= err_nx;
        valid      <= 1'b1;
      end else if (hs) begin
        valid     <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
